icache_nway: RTL and testbench

- Parametrised N-way set-associative, read-only instruction cache: datapath plus miss controller in one block.
- Successor to the fixed 2-way/8-set I-cache datapath, generalised in ways, sets and line width.
- Adds a tree pseudo-LRU, its own fill FSM with the physical-memory handshake, and a full-cache flush.
- Sits between the fetch stage (mem_*) and the arbiter/L2 (pmem_*).

---
 rtl/icache_nway_pkg.sv | 30 +++
 rtl/icache_nway_array.sv | 22 ++
 rtl/icache_nway_plru_tree.sv | 33 +++
 rtl/icache_nway.sv | 185 ++++++++++++++++++
 tb/tb_icache_nway.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/icache_nway_pkg.sv
// Shared types and width helpers for the N-way instruction cache.
// Optional ICACHE_PERF_CNT_EN adds hit/miss counters to icache_nway.
package icache_nway_pkg;

  typedef logic [15:0] lc3b_word;
  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FILL
  } icache_state_t;

  function automatic int off_w(input int line_bits);
    return $clog2(line_bits / 8);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(
    input int addr_bits,
    input int line_bits,
    input int sets
  );
    return addr_bits - off_w(line_bits) - idx_w(sets);
  endfunction

endpackage

// File: rtl/icache_nway_array.sv
// Per-way storage array: asynchronous read, synchronous write.
// No reset; contents are qualified by the valid flops in the top.
module icache_nway_array #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/icache_nway_plru_tree.sv
// Tree pseudo-LRU for one set: victim walk and access update.
// Bit value selects the victim side at each node (0 left, 1 right).
module plru_tree #(
  parameter int WAYS = 2,
  localparam int LW = $clog2(WAYS)
) (
  input  logic [LW-1:0]   access_way,
  input  logic            access_en,
  input  logic [WAYS-2:0] bits,
  output logic [WAYS-2:0] next_bits,
  output logic [LW-1:0]   victim_way
);

  always_comb begin
    int node;
    next_bits = bits;
    node = 1;
    for (int l = 0; l < LW; l++) begin
      if (access_en) next_bits[node-1] = ~access_way[LW-1-l];
      node = 2 * node + int'(access_way[LW-1-l]);
    end
  end

  always_comb begin
    int node;
    node = 1;
    for (int l = 0; l < LW; l++) begin
      node = 2 * node + int'(bits[node-1]);
    end
    victim_way = LW'(node - WAYS);
  end

endmodule

// File: rtl/icache_nway.sv
// N-way set-associative read-only I-cache with tree PLRU and fill FSM.
// Define ICACHE_PERF_CNT_EN to add hit_count/miss_count outputs.
module icache_nway
  import icache_nway_pkg::*;
#(
  parameter int WAYS      = 2,
  parameter int SETS      = 8,
  parameter int LINE_BITS = 128,
  parameter int ADDR_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mem_read,
  input  logic [ADDR_BITS-1:0] mem_address,
  output lc3b_word             mem_rdata,
  output logic                 mem_resp,
  input  logic                 flush,
  output logic                 pmem_read,
  output logic [ADDR_BITS-1:0] pmem_address,
  input  logic [LINE_BITS-1:0] pmem_rdata,
  input  logic                 pmem_resp
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count
`endif
);

  localparam int OFF = off_w(LINE_BITS);
  localparam int IDX = idx_w(SETS);
  localparam int TAG = tag_w(ADDR_BITS, LINE_BITS, SETS);
  localparam int WW  = $clog2(WAYS);

  icache_state_t state;

  logic [TAG-1:0] tag;
  logic [IDX-1:0] index;
  logic [OFF-2:0] wsel;
  logic           unused_bit0;

  assign tag         = mem_address[ADDR_BITS-1 -: TAG];
  assign index       = mem_address[OFF +: IDX];
  assign wsel        = mem_address[OFF-1:1];
  assign unused_bit0 = mem_address[0];

  logic [WAYS-1:0]      valid_q [SETS];
  logic [WAYS-2:0]      plru_q  [SETS];
  logic [TAG-1:0]       tag_rd  [WAYS];
  logic [LINE_BITS-1:0] data_rd [WAYS];
  logic [WW-1:0]        victim_q;
  logic                 flush_pend;
  logic                 fill_we;

  assign fill_we = (state == FETCH) && pmem_resp;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic we;
    assign we = fill_we && (victim_q == WW'(w));

    icache_nway_array #(.WIDTH(TAG), .DEPTH(SETS)) u_tag (
      .clk   (clk),
      .we    (we),
      .addr  (index),
      .wdata (tag),
      .rdata (tag_rd[w])
    );

    icache_nway_array #(.WIDTH(LINE_BITS), .DEPTH(SETS)) u_data (
      .clk   (clk),
      .we    (we),
      .addr  (index),
      .wdata (pmem_rdata),
      .rdata (data_rd[w])
    );
  end

  logic          hit;
  logic [WW-1:0] hit_way;
  logic          inv_found;
  logic [WW-1:0] inv_way;

  // Descending scans leave the lowest-numbered match selected.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[index][w] && tag_rd[w] == tag) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
      if (!valid_q[index][w]) begin
        inv_found = 1'b1;
        inv_way   = WW'(w);
      end
    end
  end

  logic lookup_miss;
  assign mem_resp    = (state == IDLE) && mem_read && hit;
  assign lookup_miss = (state == IDLE) && mem_read && !hit;

  logic [LINE_BITS-1:0] hit_line;
  assign hit_line  = data_rd[hit_way];
  assign mem_rdata = mem_resp ? hit_line[{wsel, 4'b0} +: 16] : '0;

  logic [WAYS-2:0] plru_next;
  logic [WW-1:0]   plru_victim;

  plru_tree #(.WAYS(WAYS)) u_plru (
    .access_way (fill_we ? victim_q : hit_way),
    .access_en  (mem_resp || fill_we),
    .bits       (plru_q[index]),
    .next_bits  (plru_next),
    .victim_way (plru_victim)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pmem_read    <= 1'b0;
      pmem_address <= '0;
      victim_q     <= '0;
      flush_pend   <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      if (mem_resp || fill_we) plru_q[index] <= plru_next;
      unique case (state)
        IDLE: begin
          if (flush || flush_pend) begin
            for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
          end
          flush_pend <= 1'b0;
          if (lookup_miss) begin
            state        <= FETCH;
            pmem_read    <= 1'b1;
            pmem_address <= {tag, index, {OFF{1'b0}}};
            victim_q     <= inv_found ? inv_way : plru_victim;
          end
        end
        FETCH: begin
          if (flush) flush_pend <= 1'b1;
          if (pmem_resp) begin
            valid_q[index][victim_q] <= 1'b1;
            pmem_read <= 1'b0;
            state     <= FILL;
          end
        end
        FILL: begin
          if (flush) flush_pend <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  // The post-fill response belongs to the miss, not to a hit.
  logic retry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
      retry_q    <= 1'b0;
    end else begin
      retry_q <= (state == FILL);
      if (mem_resp && !retry_q) hit_count <= hit_count + 32'd1;
      if (lookup_miss) miss_count <= miss_count + 32'd1;
    end
  end
`endif

  a_addr_stable: assert property (
    @(posedge clk) disable iff (!rst_n)
    (state == FETCH) |->
      mem_address[ADDR_BITS-1:OFF] == pmem_address[ADDR_BITS-1:OFF]
  );

endmodule

// File: tb/tb_icache_nway.sv
// Directed self-checking bench for icache_nway (WAYS=4, 8 sets, 128b lines).
// Honours ICACHE_PERF_CNT_EN when the counters are built in.
module tb_icache_nway;

  logic         clk;
  logic         rst_n;
  logic         mem_read;
  logic [15:0]  mem_address;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic         flush;
  logic         pmem_read;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  int total = 0;
  int bad   = 0;

  icache_nway #(
    .WAYS(4), .SETS(8), .LINE_BITS(128), .ADDR_BITS(16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
    .flush        (flush),
    .pmem_read    (pmem_read),
    .pmem_address (pmem_address),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] mkline(input logic [15:0] a);
    logic [127:0] l;
    logic [15:0]  b;
    b = {a[15:4], 4'h0};
    for (int k = 0; k < 8; k++) l[k*16 +: 16] = b + 16'h1111 * 16'(k + 1);
    if (b == 16'h1230) l[47:32] = 16'hBEEF;
    return l;
  endfunction

  function automatic logic [15:0] word_of(input logic [15:0] a);
    logic [127:0] l;
    l = mkline(a);
    return l[{a[3:1], 4'b0} +: 16];
  endfunction

  // Called at a negedge; fmode 1 pulses flush in the lookup cycle,
  // fmode 2 pulses flush during FETCH.
  task automatic run_read(
    input logic [15:0] a,
    input bit          exp_hit,
    input int          fmode,
    input string       nm
  );
    int  c;
    int  rc;
    bit  seen;
    bit  done;
    mem_read    = 1'b1;
    mem_address = a;
    seen = 0; done = 0; rc = -1; c = 0;
    while (c < 20 && !done) begin
      if (fmode == 1 && c == 0) flush = 1'b1;
      #1;
      if (pmem_read && !seen) begin
        seen = 1; rc = c;
        total++;
        if (pmem_address !== {a[15:4], 4'h0}) begin
          bad++;
          $display("FAIL %s paddr got=%h exp=%h", nm, pmem_address,
                   {a[15:4], 4'h0});
        end
        pmem_rdata = mkline(a);
        pmem_resp  = 1'b1;
        if (fmode == 2) flush = 1'b1;
      end
      if (mem_resp) begin
        done = 1;
        total++;
        if (exp_hit ? (seen || c != 0) : (!seen || c != rc + 2)) begin
          bad++;
          $display("FAIL %s timing got_cyc=%0d pmem=%0d exp_hit=%0d",
                   nm, c, seen, exp_hit);
        end
        total++;
        if (mem_rdata !== word_of(a)) begin
          bad++;
          $display("FAIL %s rdata got=%h exp=%h", nm, mem_rdata,
                   word_of(a));
        end
      end
      @(negedge clk);
      pmem_resp = 1'b0;
      flush     = 1'b0;
      c++;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL %s timeout got=no_resp exp=resp", nm);
    end
    mem_read = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_read = 1'b1; mem_address = 16'h1234;
    @(negedge clk); #1;
    total++;
    if ({mem_resp, pmem_read} !== 2'b00) begin
      bad++;
      $display("FAIL reset_hs got=%b exp=00", {mem_resp, pmem_read});
    end
    total++;
    if (pmem_address !== 16'h0 || mem_rdata !== 16'h0) begin
      bad++;
      $display("FAIL reset_data got=%h/%h exp=0/0", pmem_address, mem_rdata);
    end
    @(negedge clk);
    mem_read = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cold_miss();
    run_read(16'h1234, 0, 0, "cold_miss");
    run_read(16'h1234, 1, 0, "warm_hit");
    run_read(16'h1235, 1, 0, "bit0_ignored");
    run_read(16'h123E, 1, 0, "last_word");
  endtask

  task automatic test_conflict();
    run_read(16'h0000, 0, 0, "fill_w0");
    run_read(16'h0080, 0, 0, "fill_w1");
    run_read(16'h0100, 0, 0, "fill_w2");
    run_read(16'h0180, 0, 0, "fill_w3");
    run_read(16'h0000, 1, 0, "touch_w0");
    run_read(16'h0200, 0, 0, "evict");
    run_read(16'h0000, 1, 0, "w0_kept");
    run_read(16'h0080, 1, 0, "w1_kept");
    run_read(16'h0180, 1, 0, "w3_kept");
    run_read(16'h0100, 0, 0, "w2_evicted");
    run_read(16'h0200, 1, 0, "new_line");
  endtask

  task automatic test_flush_idle();
    run_read(16'h1234, 1, 0, "pre_flush");
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    run_read(16'h1234, 0, 0, "post_flush");
    run_read(16'h1234, 1, 1, "flush_with_hit");
    run_read(16'h1234, 0, 0, "after_flush_hit");
  endtask

  task automatic test_flush_fetch();
    run_read(16'h2002, 0, 2, "flush_in_fetch");
    run_read(16'h2002, 0, 0, "miss_after_pend");
  endtask

  task automatic test_reset_fetch();
    int n;
    mem_read = 1'b1; mem_address = 16'h5006;
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (!pmem_read && n < 10);
    total++;
    if (pmem_read !== 1'b1) begin
      bad++;
      $display("FAIL rst_fetch_req got=%b exp=1", pmem_read);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (pmem_read !== 1'b0 || pmem_address !== 16'h0) begin
      bad++;
      $display("FAIL rst_fetch_drop got=%b/%h exp=0/0000", pmem_read,
               pmem_address);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mem_read = 1'b0;
    pmem_rdata = mkline(16'h5006);
    pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    run_read(16'h5006, 0, 0, "stale_ignored");
    run_read(16'h1234, 0, 0, "rst_cleared");
  endtask

  task automatic test_back_to_back();
    run_read(16'h5006, 1, 0, "b2b_a");
    run_read(16'h5008, 1, 0, "b2b_b");
    run_read(16'h1232, 1, 0, "b2b_c");
  endtask

`ifdef ICACHE_PERF_CNT_EN
  task automatic test_perf();
    logic [31:0] h0;
    logic [31:0] m0;
    h0 = hit_count; m0 = miss_count;
    run_read(16'h3000, 0, 0, "perf_miss1");
    run_read(16'h3000, 1, 0, "perf_hit1");
    run_read(16'h3002, 1, 0, "perf_hit2");
    run_read(16'h4000, 0, 0, "perf_miss2");
    total++;
    if (hit_count - h0 !== 32'd2) begin
      bad++;
      $display("FAIL perf_hits got=%0d exp=2", hit_count - h0);
    end
    total++;
    if (miss_count - m0 !== 32'd2) begin
      bad++;
      $display("FAIL perf_misses got=%0d exp=2", miss_count - m0);
    end
  endtask
`endif

  initial begin
    mem_read = 1'b0; mem_address = '0; flush = 1'b0;
    pmem_rdata = '0; pmem_resp = 1'b0; rst_n = 1'b0;
    test_reset();
    test_cold_miss();
    test_conflict();
    test_flush_idle();
    test_flush_fetch();
    test_reset_fetch();
    test_back_to_back();
`ifdef ICACHE_PERF_CNT_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
